// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data memory) arbiter onto a single shared bus.
// The data port wins ties; a wait-cycle counter flags a sticky bus error on timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                iClk,
    input  logic                nRst,

    input  logic                iIF_req,
    input  logic [ADDR_W-1:0]   iIF_addr,
    output logic [DATA_W-1:0]   oIF_rdata,
    output logic                oStall_IF,
    input  logic                iFlush_IF,

    input  logic                iME_req,
    input  logic                iME_we,
    input  logic [DATA_W/8-1:0] iME_be,
    input  logic [ADDR_W-1:0]   iME_addr,
    input  logic [DATA_W-1:0]   iME_wdata,
    output logic [DATA_W-1:0]   oME_rdata,
    output logic                oStall_ME,

    output logic                oBus_valid,
    output logic                oBus_we,
    output logic [DATA_W/8-1:0] oBus_be,
    output logic [ADDR_W-1:0]   oBus_addr,
    output logic [DATA_W-1:0]   oBus_wdata,
    input  logic                iBus_ready,
    input  logic                iBus_rvalid,
    input  logic [DATA_W-1:0]   iBus_rdata,

    output logic                oBusErr
);

    localparam int unsigned BE_W        = DATA_W / 8;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic                grant_me_q,   grant_me_d;
    logic                bus_valid_q,  bus_valid_d;
    logic                bus_we_q,     bus_we_d;
    logic [BE_W-1:0]     bus_be_q,     bus_be_d;
    logic [ADDR_W-1:0]   bus_addr_q,   bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q,  bus_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]   me_rdata_q,   me_rdata_d;
    logic                done_if_q,    done_if_d;
    logic                done_me_q,    done_me_d;
    logic                drop_q,       drop_d;
    logic [7:0]          cnt_q,        cnt_d;
    logic                err_q,        err_d;

    logic                timeout;
    logic                dropped;

    assign timeout = (cnt_q == TIMEOUT_CNT);
    // A flush arriving in the same cycle as the response still discards it.
    assign dropped = drop_q | iFlush_IF;

    always_comb begin
        state_d     = state_q;
        grant_me_d  = grant_me_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        me_rdata_d  = me_rdata_q;
        done_if_d   = 1'b0;
        done_me_d   = 1'b0;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (iME_req && !done_me_q) begin
                    grant_me_d  = 1'b1;
                    bus_valid_d = 1'b1;
                    bus_we_d    = iME_we;
                    bus_be_d    = iME_be;
                    bus_addr_d  = iME_addr;
                    bus_wdata_d = iME_wdata;
                    cnt_d       = '0;
                    state_d     = ADDR;
                end else if (iIF_req && !done_if_q && !iFlush_IF) begin
                    grant_me_d  = 1'b0;
                    bus_valid_d = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = iIF_addr;
                    bus_wdata_d = '0;
                    cnt_d       = '0;
                    state_d     = ADDR;
                end
            end

            ADDR, DATA: begin
                cnt_d = 8'(cnt_q + 8'd1);
                if (!grant_me_q && iFlush_IF) begin
                    drop_d = 1'b1;
                end

                if (timeout) begin
                    err_d       = 1'b1;
                    bus_valid_d = 1'b0;
                    drop_d      = 1'b0;
                    state_d     = IDLE;
                    if (grant_me_q) begin
                        me_rdata_d = '0;
                        done_me_d  = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        done_if_d  = !dropped;
                    end
                end else if (state_q == ADDR) begin
                    if (iBus_ready) begin
                        bus_valid_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = DATA;
                    end
                end else if (iBus_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = IDLE;
                    if (grant_me_q) begin
                        me_rdata_d = iBus_rdata;
                        done_me_d  = 1'b1;
                    end else if (!dropped) begin
                        if_rdata_d = iBus_rdata;
                        done_if_d  = 1'b1;
                    end
                end
            end

            default: begin
                bus_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            grant_me_q  <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            me_rdata_q  <= '0;
            done_if_q   <= 1'b0;
            done_me_q   <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_me_q  <= grant_me_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            me_rdata_q  <= me_rdata_d;
            done_if_q   <= done_if_d;
            done_me_q   <= done_me_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign oStall_IF  = iIF_req & ~done_if_q;
    assign oStall_ME  = iME_req & ~done_me_q;
    assign oIF_rdata  = if_rdata_q;
    assign oME_rdata  = me_rdata_q;
    assign oBus_valid = bus_valid_q;
    assign oBus_we    = bus_we_q;
    assign oBus_be    = bus_be_q;
    assign oBus_addr  = bus_addr_q;
    assign oBus_wdata = bus_wdata_q;
    assign oBusErr    = err_q;

endmodule
